dram_readout_streamer: RTL and testbench

- Downstream drain stage for the image downsampling processor.
- When the processor reports completion on processor_status, it sweeps the data RAM read port (dRamAddr/dRamOut) over the downsampled image region.
- It emits each pixel byte, in address order, on a valid/ready byte stream for the output interface (UART/host link).
- It replaces the testbench-style sequential address sweep with a synthesizable, backpressure-aware controller.

---
 rtl/dram_readout_streamer.sv | 152 +++++++++++++++
 tb/tb_dram_readout_streamer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_readout_streamer.sv
// dram_readout_streamer: drains the downsampled image from the data RAM read
// port onto a valid/ready byte stream once the processor reports completion.
module dram_readout_streamer #(
  parameter int unsigned ADDR_WIDTH   = 19,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned NUM_PIXELS   = 16384,
  parameter int unsigned DRAM_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  processor_status,
  output logic [ADDR_WIDTH-1:0] dRamAddr,
  input  logic [DATA_WIDTH-1:0] dRamOut,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  stream_done
);

  localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH + DRAM_LATENCY + 2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    prev_status_q;
  logic                    issue_q, issue_d;
  logic [CNT_W-1:0]        issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]        out_cnt_q, out_cnt_d;
  logic [DRAM_LATENCY-1:0] vld_sr_q, vld_sr_d;
  logic [ADDR_WIDTH-1:0]   addr_d;

  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0]       fcnt_q;

  logic                    start;
  logic                    push;
  logic                    xfer;
  logic [OCC_W-1:0]        inflight;
  logic [OCC_W-1:0]        occ_next;

  // FIFO head is presented directly; data is forced to zero while empty
  always_comb begin
    m_valid = (fcnt_q != '0);
    m_data  = m_valid ? mem_q[rd_ptr_q] : '0;
  end

  // Handshake events, read-return push and occupancy seen by next cycle's issue gate
  always_comb begin
    start    = processor_status && !prev_status_q;
    xfer     = m_valid && m_ready;
    push     = vld_sr_q[DRAM_LATENCY-1];
    vld_sr_d = DRAM_LATENCY'({vld_sr_q, issue_q});
    inflight = '0;
    for (int i = 0; i < int'(DRAM_LATENCY); i++) begin
      inflight = inflight + OCC_W'(vld_sr_q[i]);
    end
    // Next cycle: FIFO gains this cycle's oldest return, inflight gains this
    // cycle's issue and loses that return, FIFO loses this cycle's transfer.
    occ_next = OCC_W'(fcnt_q) + inflight + OCC_W'(issue_q) - OCC_W'(xfer);
  end

  // Next-state, counters and the issue decision for the following cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_STREAM;
      S_STREAM: if (xfer && (out_cnt_q == CNT_W'(NUM_PIXELS - 1))) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    issue_cnt_d = '0;
    out_cnt_d   = '0;
    if (state_d == S_STREAM) begin
      issue_cnt_d = issue_cnt_q + CNT_W'(issue_q);
      out_cnt_d   = out_cnt_q + CNT_W'(xfer);
    end

    issue_d = (state_d == S_STREAM) &&
              (issue_cnt_d < CNT_W'(NUM_PIXELS)) &&
              (occ_next < OCC_W'(FIFO_DEPTH));

    // Address register is loaded one cycle ahead so it is on the port during the issue cycle
    addr_d = ADDR_WIDTH'(BASE_ADDR);
    if (issue_d) begin
      addr_d = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(issue_cnt_d);
    end else if (state_d == S_STREAM) begin
      addr_d = dRamAddr;
    end
  end

  // Control state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      prev_status_q <= 1'b0;
      issue_q       <= 1'b0;
      issue_cnt_q   <= '0;
      out_cnt_q     <= '0;
      vld_sr_q      <= '0;
      dRamAddr      <= '0;
      busy          <= 1'b0;
      stream_done   <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_status_q <= processor_status;
      issue_q       <= issue_d;
      issue_cnt_q   <= issue_cnt_d;
      out_cnt_q     <= out_cnt_d;
      vld_sr_q      <= vld_sr_d;
      dRamAddr      <= addr_d;
      busy          <= (state_d == S_STREAM);
      stream_done   <= (state_d == S_DONE);
    end
  end

  // FIFO pointers and occupancy; reset flushes by clearing them
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (xfer) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      fcnt_q <= fcnt_q + FCNT_W'(push) - FCNT_W'(xfer);
    end
  end

  // FIFO storage captures returning RAM data
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= dRamOut;
    end
  end

endmodule

// File: tb/tb_dram_readout_streamer.sv
// Bench for dram_readout_streamer: behavioural stream model plus directed
// timing checks for the main configuration and a single-pixel configuration.
module tb_dram_readout_streamer;

  localparam int AW   = 19;
  localparam int N    = 11;
  localparam int BASE = 0;
  localparam int L    = 1;
  localparam int D    = 4;

  logic          clk;
  logic          reset;
  logic          ps0, ps1;
  logic [AW-1:0] addr0, addr1;
  logic [7:0]    dout0, dout1;
  logic [7:0]    mdata0, mdata1;
  logic          mvalid0, mvalid1;
  logic          mready0, mready1;
  logic          busy0, busy1;
  logic          done0, done1;

  int n_chk  = 0;
  int n_pass = 0;

  dram_readout_streamer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(8), .BASE_ADDR(BASE), .NUM_PIXELS(N),
    .DRAM_LATENCY(L), .FIFO_DEPTH(D)
  ) u0 (
    .clk(clk), .reset(reset), .processor_status(ps0), .dRamAddr(addr0),
    .dRamOut(dout0), .m_data(mdata0), .m_valid(mvalid0), .m_ready(mready0),
    .busy(busy0), .stream_done(done0)
  );

  dram_readout_streamer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(8), .BASE_ADDR(0), .NUM_PIXELS(1),
    .DRAM_LATENCY(2), .FIFO_DEPTH(4)
  ) u1 (
    .clk(clk), .reset(reset), .processor_status(ps1), .dRamAddr(addr1),
    .dRamOut(dout1), .m_data(mdata1), .m_valid(mvalid1), .m_ready(mready1),
    .busy(busy1), .stream_done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: pixel value is the low address byte xor A5
  logic [7:0] ram1_a;
  always @(posedge clk) begin
    dout0  <= addr0[7:0] ^ 8'hA5;
    ram1_a <= addr1[7:0] ^ 8'hA5;
    dout1  <= ram1_a;
  end

  function automatic logic [7:0] pix(input int a);
    logic [7:0] lo;
    lo = a[7:0];
    return lo ^ 8'hA5;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model of the stream, checked every cycle on the falling edge
  bit         mon_en = 0;
  bit         m_busy, m_done, m_prev_ps, prev_v, prev_r;
  int         m_cnt, m_age, m_prev_addr;
  logic [7:0] prev_d;

  always @(negedge clk) begin
    if (reset) begin
      mon_en = 1; m_busy = 0; m_done = 0; m_cnt = 0; m_age = 0;
      m_prev_ps = 0; prev_v = 0; prev_r = 0;
    end else if (mon_en) begin
      bit start, xfer;
      chk("busy", busy0, m_busy);
      chk("stream_done", done0, m_done);
      if (m_busy) begin
        if (m_age == 0) chk("first addr", addr0, BASE);
        else chk("addr step", (int'(addr0) == m_prev_addr) || (int'(addr0) == m_prev_addr + 1), 1);
        chk("addr bound", int'(addr0) <= BASE + N - 1, 1);
        chk("outstanding", (int'(addr0) - BASE + 1 - m_cnt) <= D, 1);
        if (m_age <= L) chk("valid before latency", mvalid0, 0);
        else if (m_age == L + 1) chk("valid at latency", mvalid0, 1);
      end else begin
        chk("valid outside stream", mvalid0, 0);
      end
      if (!m_busy && !m_done) chk("idle addr", addr0, BASE);
      if (mvalid0) chk("byte order", mdata0, pix(BASE + m_cnt));
      if (prev_v && !prev_r) begin
        chk("stall valid", mvalid0, 1);
        chk("stall data", mdata0, prev_d);
      end
      start = ps0 && !m_prev_ps;
      xfer  = mvalid0 && mready0;
      m_prev_ps = ps0; prev_v = mvalid0; prev_r = mready0; prev_d = mdata0;
      m_prev_addr = int'(addr0);
      if (m_done) m_done = 0;
      else if (m_busy) begin
        m_age++;
        if (xfer) begin
          m_cnt++;
          if (m_cnt == N) begin m_busy = 0; m_done = 1; end
        end
      end else if (start) begin
        m_busy = 1; m_age = 0; m_cnt = 0;
      end
    end
  end

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (done0) seen = 1;
    end
    chk("done within budget", seen, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] lit [0:10];
  logic [7:0] got [0:15];
  int         addr_seen [0:10];

  initial begin
    int first_busy, first_valid, done_at, ndone, nb, p, nx;
    bit seen;
    lit = '{8'hA5, 8'hA4, 8'hA7, 8'hA6, 8'hA1, 8'hA0, 8'hA3, 8'hA2, 8'hAD, 8'hAC, 8'hAF};

    // Reset with status already high; stream must start right at release
    reset = 1; ps0 = 1; ps1 = 0; mready0 = 1; mready1 = 1;
    step();
    chk("reset addr", addr0, 0);
    chk("reset valid", mvalid0, 0);
    chk("reset busy", busy0, 0);
    chk("reset done", done0, 0);
    chk("reset data", mdata0, 0);
    step(); step();
    reset = 0;
    step();
    chk("release start busy", busy0, 1);
    chk("release start addr", addr0, 0);
    wait_done(60);

    // Status held high after completion must not restart
    for (int i = 0; i < 20; i++) step();
    chk("no restart while high", busy0, 0);

    // Basic stream with full throughput
    ps0 = 0; step(); ps0 = 1;
    first_busy = -1; first_valid = -1; done_at = -1; ndone = 0; nb = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (busy0 && first_busy < 0) first_busy = i;
      if (i <= 11) addr_seen[i-1] = int'(addr0);
      if (mvalid0 && first_valid < 0) first_valid = i;
      if (mvalid0 && mready0 && nb < 16) begin got[nb] = mdata0; nb++; end
      if (done0) begin ndone++; if (done_at < 0) done_at = i; end
    end
    chk("basic first busy", first_busy, 1);
    for (int k = 0; k < 11; k++) chk("basic addr sweep", addr_seen[k], k);
    chk("basic first valid", first_valid, 3);
    chk("basic byte count", nb, 11);
    for (int k = 0; k < 11; k++) chk("basic byte literal", got[k], lit[k]);
    chk("basic done cycle", done_at, 14);
    chk("basic done pulses", ndone, 1);

    // Backpressure: 1,0,1,0 then a 10-cycle stall, then ready
    ps0 = 0; mready0 = 0; step(); ps0 = 1;
    p = 0; nb = 0; ndone = 0;
    for (int i = 1; i <= 80; i++) begin
      step();
      if (mvalid0 || p > 0) begin
        if (p == 13) chk("addr stops at window", addr0, 5);
        mready0 = (p < 4) ? (p % 2 == 0) : (p >= 14);
        p++;
      end
      if (mvalid0 && mready0 && nb < 16) begin got[nb] = mdata0; nb++; end
      if (done0) ndone++;
    end
    chk("bp byte count", nb, 11);
    for (int k = 0; k < 11; k++) chk("bp byte literal", got[k], lit[k]);
    chk("bp done pulses", ndone, 1);

    // Random backpressure streams
    for (int s = 0; s < 4; s++) begin
      ps0 = 0; mready0 = 1; step(); ps0 = 1;
      seen = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
        step();
        if (done0) seen = 1;
        mready0 = ($urandom_range(0, 3) != 0);
      end
      chk("random stream done", seen, 1);
    end
    mready0 = 1;

    // Reset after five transfers aborts the stream
    ps0 = 0; step(); ps0 = 1;
    nx = 0;
    for (int i = 0; i < 40 && nx < 5; i++) begin
      step();
      if (mvalid0 && mready0) nx++;
    end
    chk("five transfers reached", nx, 5);
    step();
    reset = 1; ps0 = 0;
    step();
    chk("abort valid", mvalid0, 0);
    chk("abort busy", busy0, 0);
    chk("abort addr", addr0, 0);
    chk("abort done", done0, 0);
    reset = 0;
    for (int i = 0; i < 5; i++) step();
    ps0 = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (mvalid0) begin seen = 1; chk("restart first byte", mdata0, 8'hA5); end
    end
    chk("restart valid seen", seen, 1);
    wait_done(60);

    // Single pixel with two-cycle RAM latency
    ps1 = 1;
    first_busy = -1; first_valid = -1; done_at = -1; ndone = 0; nb = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (busy1 && first_busy < 0) begin first_busy = i; chk("edge first addr", addr1, 0); end
      if (mvalid1) begin
        nb++;
        if (first_valid < 0) begin first_valid = i; chk("edge byte", mdata1, 8'hA5); end
      end
      if (done1) begin ndone++; if (done_at < 0) done_at = i; end
    end
    chk("edge first busy", first_busy, 1);
    chk("edge first valid", first_valid, 4);
    chk("edge valid cycles", nb, 1);
    chk("edge done cycle", done_at, 5);
    chk("edge done pulses", ndone, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
